key_event_ctrl: RTL
===================

# key_event_ctrl

Key-event classifier placed directly downstream of the push-button synchroniser/falling-edge detector. Consumes the one-cycle press pulse and the synchronised key level. Classifies each gesture as short press, long press or (optionally) double click, and queues 2-bit event codes in a small FIFO. The picorv32 GPIO/interrupt logic pops the FIFO through a valid/ready handshake.

## Interface
- LONG_CYCLES, 27_000_000: hold time for a long press (1 s at 27 MHz).
- DCLICK_CYCLES, 8_100_000: window after release for a second press.
- FIFO_DEPTH, 4: event queue depth; power of 2, ≥2.
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- press_pulse  in  1  one-cycle press strobe from the edge detector.
- key_level  in  1  synchronised key level, 0 = held. Aligned with press_pulse: it is 0 in every cycle where press_pulse=1.
- evt_valid  out  1  FIFO non-empty.
- evt_code  out  2  head event: 01 short, 10 long, 11 double; 00 when empty.
- evt_ready  in  1  pop strobe; effective only when evt_valid=1.
- overflow  out  1  sticky flag: an event was dropped.
- ovf_clr  in  1  clears overflow.

## Operation
- Event counter: width $clog2(max(LONG_CYCLES, DCLICK_CYCLES)). Cleared on every state entry; increments each cycle in a timed state.
- IDLE
  - press_pulse=1 → HELD.
- HELD
  - key_level=1 (released) → WAIT2 if double click is compiled in; otherwise push SHORT and go to IDLE.
  - key_level=0 and cnt==LONG_CYCLES-1 → push LONG and go to LONGHOLD.
  - Release in the same cycle as cnt==LONG_CYCLES-1: release wins.
- LONGHOLD
  - key_level=1 → IDLE. No further event is pushed.
- WAIT2
  - press_pulse=1 → push DOUBLE and go to LONGHOLD. The second press is never timed as long.
  - cnt==DCLICK_CYCLES-1 → push SHORT and go to IDLE.
  - press_pulse on the timeout cycle: DOUBLE wins.
- press_pulse in HELD/LONGHOLD is ignored.
- FIFO behaviour:
  - First-word fall-through; evt_code shows the head entry.
  - Push when full with no pop: event dropped, overflow set.
  - Push and pop in the same cycle when full: both happen, no overflow.
  - Pop when empty: ignored.
- overflow: set has priority over ovf_clr in the same cycle.
- Reset (also mid-gesture):
  - FSM → IDLE, counter 0, FIFO emptied.
  - evt_valid=0, evt_code=00, overflow=0.
  - No event is generated for a gesture interrupted by reset.

## Timing
- A push decided in cycle N is written at the clk edge ending N; evt_valid and evt_code update in cycle N+1.
- With press_pulse in cycle 0, HELD is entered in cycle 1 with cnt=0. LONG is decided in cycle LONG_CYCLES and visible in cycle LONG_CYCLES+1.
- SHORT without double click: release sampled in cycle R, visible in R+1.
- SHORT with double click: WAIT2 is entered in R+1, timeout is decided in R+DCLICK_CYCLES, visible in R+DCLICK_CYCLES+1.
- Pop: the FIFO head advances on the edge ending the cycle where evt_valid&evt_ready=1.
- No combinational path from inputs to outputs.

## Configuration
- KEY_DOUBLE_CLICK_EN defined: WAIT2 exists and DOUBLE events are produced; SHORT is delayed by the double-click window.
- KEY_DOUBLE_CLICK_EN undefined:
  - WAIT2 and DCLICK_CYCLES logic are removed; DCLICK_CYCLES is ignored.
  - Release in HELD pushes SHORT immediately.
  - Code 11 is never produced.

## Structure
- Package key_evt_pkg holds:
  - the state enum (IDLE, HELD, LONGHOLD, WAIT2);
  - localparams EVT_NONE=2'b00, EVT_SHORT=2'b01, EVT_LONG=2'b10, EVT_DOUBLE=2'b11.
- Sub-module key_evt_fifo: parameterised-depth first-word-fall-through FIFO with push/pop/full/empty. Overflow detection stays in key_event_ctrl.

## Test plan
Settings for all scenarios: LONG_CYCLES=16, DCLICK_CYCLES=8, FIFO_DEPTH=4, evt_ready=0 unless stated; press_pulse in cycle 0.
- Short press, double click disabled: release in cycle 5 → evt_valid=1 and evt_code=01 from cycle 6. With double click enabled → evt_valid from cycle 14.
- Hold for 40 cycles → exactly one event, code 10, visible from cycle 17. The release in cycle 40 adds nothing.
- Double click (enabled): release in cycle 3, second press_pulse in cycle 6 → a single event 11, then no event after the second release.
- Overflow: five short gestures with evt_ready=0 → four entries and overflow=1. Four pops each return 01, then evt_valid=0. Pulsing ovf_clr → overflow=0.
- Full FIFO with a push and evt_ready=1 in the same cycle → entry count stays 4 and overflow stays 0.
- rstn low for 1 cycle in cycle 8 of a hold, release in cycle 30 → evt_valid stays 0 and overflow stays 0.

Source files
------------

// File: rtl/key_event_ctrl_pkg.sv
// Shared types for the key-event classifier: FSM state encoding, event codes
// and small elaboration-time helpers.
package key_evt_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HELD     = 2'd1,
    LONGHOLD = 2'd2,
    WAIT2    = 2'd3
  } key_state_e;

  localparam logic [1:0] EVT_NONE   = 2'b00;
  localparam logic [1:0] EVT_SHORT  = 2'b01;
  localparam logic [1:0] EVT_LONG   = 2'b10;
  localparam logic [1:0] EVT_DOUBLE = 2'b11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width for a timer that must reach cycles-1; never narrower than 1 bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_event_ctrl_if.sv
// Bundle between the key-event classifier and its producer (edge detector)
// and consumer (GPIO/interrupt logic).
interface key_event_ctrl_if;

  logic       press_pulse;
  logic       key_level;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready;
  logic       overflow;
  logic       ovf_clr;

  // evt_valid is high while the event queue holds an entry and evt_code shows
  // the head; an entry is consumed on the clock edge ending a cycle with
  // evt_valid=1 and evt_ready=1. evt_ready while evt_valid=0 has no effect.
  modport slave (
    input  press_pulse,
    input  key_level,
    input  evt_ready,
    input  ovf_clr,
    output evt_valid,
    output evt_code,
    output overflow
  );

  modport master (
    output press_pulse,
    output key_level,
    output evt_ready,
    output ovf_clr,
    input  evt_valid,
    input  evt_code,
    input  overflow
  );

endinterface

// File: rtl/key_event_ctrl_fifo.sv
// First-word-fall-through event queue; DEPTH must be a power of two >= 2.
// A push while full is accepted only if a pop happens in the same cycle.
module key_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only looked at while non-empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Push-button gesture classifier (short / long / double click) feeding a small
// event queue. Double-click support is built only when KEY_DOUBLE_CLICK_EN is defined.
module key_event_ctrl
  import key_evt_pkg::*;
#(
  parameter int LONG_CYCLES   = 27_000_000,
  parameter int DCLICK_CYCLES = 8_100_000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  key_event_ctrl_if.slave               evt_if,
  output key_state_e                    state_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int CNT_W = cnt_width(max_int(LONG_CYCLES, DCLICK_CYCLES));
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef KEY_DOUBLE_CLICK_EN
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);
`endif

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             push;
  logic [1:0]       push_code;
  logic             pop;
  logic             fifo_full, fifo_empty;
  logic [1:0]       head_code;

  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    push_code = EVT_NONE;
    case (state_q)
      IDLE: begin
        if (evt_if.press_pulse) state_d = HELD;
      end
      HELD: begin
        // Release is checked first so it beats the long-press threshold.
        if (evt_if.key_level) begin
`ifdef KEY_DOUBLE_CLICK_EN
          state_d = WAIT2;
`else
          push      = 1'b1;
          push_code = EVT_SHORT;
          state_d   = IDLE;
`endif
        end else if (cnt_q == LONG_LAST) begin
          push      = 1'b1;
          push_code = EVT_LONG;
          state_d   = LONGHOLD;
        end
      end
      LONGHOLD: begin
        if (evt_if.key_level) state_d = IDLE;
      end
      WAIT2: begin
`ifdef KEY_DOUBLE_CLICK_EN
        // The second press is parked in LONGHOLD so it is never timed as long.
        if (evt_if.press_pulse) begin
          push      = 1'b1;
          push_code = EVT_DOUBLE;
          state_d   = LONGHOLD;
        end else if (cnt_q == DCLICK_LAST) begin
          push      = 1'b1;
          push_code = EVT_SHORT;
          state_d   = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // The timer restarts on every state change and only runs in timed states.
  always_comb begin
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == HELD || state_q == WAIT2) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

  assign pop = !fifo_empty && evt_if.evt_ready;

  always_comb begin
    ovf_d = ovf_q;
    if (push && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end else if (evt_if.ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  key_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .data_i  (push_code),
    .pop_i   (pop),
    .data_o  (head_code),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_o)
  );

  assign evt_if.evt_valid = !fifo_empty;
  assign evt_if.evt_code  = fifo_empty ? EVT_NONE : head_code;
  assign evt_if.overflow  = ovf_q;
  assign state_o          = state_q;

endmodule
